// File: rtl/hazard_ctrl.sv
// Pipeline sequencer: load-use stalls, branch flushes, memory freeze and terminal halt.
// Optional perf counters (stall_cnt, flush_cnt) are built when HAZARD_PERF_EN is defined.
module hazard_ctrl #(
  parameter int unsigned RN_W       = 4,
  parameter int unsigned BR_PENALTY = 2,
  parameter int unsigned CNT_W      = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [RN_W-1:0] id_rn1,
  input  logic [RN_W-1:0] id_rn2,
  input  logic            id_use_rn2,
  input  logic            ex_mr,
  input  logic [RN_W-1:0] ex_wn,
  input  logic            br_taken,
  input  logic            mem_busy,
  input  logic            halt_req,
  output logic            pc_we,
  output logic            ifid_we,
  output logic            ifid_flush,
  output logic            idex_we,
  output logic            idex_bubble,
  output logic            exmem_we,
  output logic            halted
`ifdef HAZARD_PERF_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
`endif
);

  typedef enum logic [1:0] {StRun, StFlush, StHalt} state_e;

  localparam logic [2:0] FlushInit = 3'(BR_PENALTY - 1);

  state_e     state_q, state_d;
  logic [2:0] fcnt_q, fcnt_d;
  logic       lu;

  assign lu = ex_mr && (ex_wn != '0) &&
              ((ex_wn == id_rn1) || (id_use_rn2 && (ex_wn == id_rn2)));

  always_comb begin
    state_d     = state_q;
    fcnt_d      = fcnt_q;
    pc_we       = 1'b0;
    ifid_we     = 1'b0;
    ifid_flush  = 1'b0;
    idex_we     = 1'b0;
    idex_bubble = 1'b0;
    exmem_we    = 1'b0;
    halted      = 1'b0;
    if (reset) begin
      state_d = StRun;
      fcnt_d  = 3'd0;
    end else if (state_q == StHalt) begin
      halted = 1'b1;
    end else if (!mem_busy) begin
      if (br_taken || (state_q == StFlush)) begin
        pc_we       = 1'b1;
        ifid_we     = 1'b1;
        ifid_flush  = 1'b1;
        idex_we     = 1'b1;
        idex_bubble = 1'b1;
        exmem_we    = 1'b1;
        if (br_taken) begin
          // A branch (re)starts the penalty; the branch cycle itself counts as one flush.
          if (BR_PENALTY > 1) begin
            state_d = StFlush;
            fcnt_d  = FlushInit;
          end else begin
            state_d = StRun;
            fcnt_d  = 3'd0;
          end
        end else if (fcnt_q <= 3'd1) begin
          state_d = StRun;
          fcnt_d  = 3'd0;
        end else begin
          fcnt_d = fcnt_q - 3'd1;
        end
      end else if (lu) begin
        idex_bubble = 1'b1;
        idex_we     = 1'b1;
        exmem_we    = 1'b1;
      end else begin
        pc_we    = 1'b1;
        ifid_we  = 1'b1;
        idex_we  = 1'b1;
        exmem_we = 1'b1;
      end
      if (halt_req && !br_taken) begin
        state_d = StHalt;
        fcnt_d  = 3'd0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StRun;
      fcnt_q  <= 3'd0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
    end
  end

`ifdef HAZARD_PERF_EN
  logic stall_ev, flush_ev;

  assign stall_ev = (state_q == StRun) && !mem_busy && !br_taken && lu;
  assign flush_ev = (state_q != StHalt) && !mem_busy && (br_taken || (state_q == StFlush));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_ev && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
      if (flush_ev && (flush_cnt != '1)) flush_cnt <= flush_cnt + 1'b1;
    end
  end
`endif

endmodule
